// File: rtl/rv32imc_types.sv
// Shared RV32IMC type definitions: M-extension funct3 encodings and the
// operand-signedness classification used by the multiplier datapath.
package rv32imc_types;

    // M-extension multiply funct3 encodings
    localparam logic [2:0] mulr    = 3'b000;
    localparam logic [2:0] mulhr   = 3'b001;
    localparam logic [2:0] mulhsur = 3'b010;
    localparam logic [2:0] mulhur  = 3'b011;

    // Operand signedness: SS = signed x signed, SU = signed a x unsigned b,
    // UU = unsigned x unsigned
    typedef enum logic [1:0] {
        MUL_SS = 2'd0,
        MUL_SU = 2'd1,
        MUL_UU = 2'd2
    } mul_sign_t;

    // Non-multiply encodings fall into MUL_UU; their result is discarded anyway.
    function automatic mul_sign_t mul_sign_of(input logic [2:0] funct3);
        mul_sign_t sign;
        case (funct3)
            mulr, mulhr: sign = MUL_SS;
            mulhsur:     sign = MUL_SU;
            default:     sign = MUL_UU;
        endcase
        return sign;
    endfunction

endpackage

// File: rtl/mul_core_comb.sv
// Purely combinational WIDTH x WIDTH -> 2*WIDTH multiplier with selectable
// operand signedness.
module mul_core_comb
    import rv32imc_types::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  mul_sign_t          sign,
    output logic [2*WIDTH-1:0] product
);

    logic                      a_signed;
    logic                      b_signed;
    logic signed [WIDTH:0]     a_ext;
    logic signed [WIDTH:0]     b_ext;
    logic signed [2*WIDTH+1:0] full;

    // Extend each operand by one bit (sign or zero) so a single signed
    // multiply covers all three signedness combinations.
    always_comb begin
        a_signed = (sign != MUL_UU);
        b_signed = (sign == MUL_SS);
        a_ext    = {a_signed & a[WIDTH-1], a};
        b_ext    = {b_signed & b[WIDTH-1], b};
        full     = (2*WIDTH+2)'(a_ext) * (2*WIDTH+2)'(b_ext);
        product  = full[2*WIDTH-1:0];
    end

endmodule

// File: rtl/mul_pipeline.sv
// Fully pipelined RV32M multiplier: one MUL/MULH/MULHSU/MULHU accepted per
// cycle, DEPTH-cycle latency, in-order results with tag, backpressure and flush.
module mul_pipeline
    import rv32imc_types::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [2:0]                 in_funct3,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       busy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic               v;
        logic [2*WIDTH-1:0] prod;
        logic [2:0]         f3;
        logic [TAG_W-1:0]   tag;
    } stage_t;

    logic               advance;
    logic               accept;
    logic               retire;
    logic [2*WIDTH-1:0] new_prod;
    stage_t             entry;
    stage_t             pipe_q [1:DEPTH];
    stage_t             head;
    logic [OCC_W-1:0]   occ_q;

    mul_core_comb #(
        .WIDTH (WIDTH)
    ) u_core (
        .a       (in_a),
        .b       (in_b),
        .sign    (mul_sign_of(in_funct3)),
        .product (new_prod)
    );

    // Handshake: the whole pipe freezes only while the head result is blocked
    always_comb begin
        head      = pipe_q[DEPTH];
        advance   = ~(head.v & ~out_ready);
        in_ready  = advance & ~flush;
        accept    = in_valid & in_ready;
        out_valid = head.v & ~flush;
        retire    = out_valid & out_ready;
    end

    // Assemble the record entering stage 1
    always_comb begin
        entry.v    = accept;
        entry.prod = new_prod;
        entry.f3   = in_funct3;
        entry.tag  = in_tag;
    end

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        stage_t prev;

        if (k == 1) begin : g_first
            // Stage 1 is fed from the product of the accepted operation
            always_comb prev = entry;
        end else begin : g_next
            // Later stages are fed from the preceding stage
            always_comb prev = pipe_q[k-1];
        end

        // Shift on advance; flush clears the valid bit even while stalled
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_q[k] <= '0;
            end else begin
                if (advance) begin
                    pipe_q[k] <= prev;
                end
                if (flush) begin
                    pipe_q[k].v <= 1'b0;
                end
            end
        end
    end

    // Select the product half requested by the head operation
    always_comb begin
        out_tag = head.tag;
        if (head.f3[2]) begin
            out_result = '0;
        end else if (head.f3 == mulr) begin
            out_result = head.prod[WIDTH-1:0];
        end else begin
            out_result = head.prod[2*WIDTH-1:WIDTH];
        end
    end

    // Track the number of valid stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else begin
            case ({accept, retire})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_comb begin
        occupancy = occ_q;
        busy      = (occ_q != '0);
    end

endmodule

// File: tb/tb_mul_pipeline.sv
// Self-checking bench for mul_pipeline (WIDTH=32, DEPTH=2, TAG_W=5).
module tb_mul_pipeline;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;
    localparam int NVEC  = 10;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [2:0]       in_funct3;
    logic [4:0]       in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [4:0]       out_tag;
    logic [1:0]       occupancy;
    logic             busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [NVEC];
    int   recv [$];

    mul_pipeline #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_funct3  (in_funct3),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .occupancy  (occupancy),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [4:0] tag);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_funct3 = f3;
        in_tag    = tag;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_funct3 = '0;
        in_tag    = '0;
    endtask

    initial begin
        int acc;
        int ret;
        int next_tag;
        bit seen;

        vecs[0] = '{32'h0000_0007, 32'hFFFF_FFFD, 3'b000, 5'd3,  32'hFFFF_FFEB};
        vecs[1] = '{32'h8000_0000, 32'h8000_0000, 3'b001, 5'd4,  32'h4000_0000};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 5'd5,  32'hFFFF_FFFE};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 5'd6,  32'hFFFF_FFFF};
        vecs[4] = '{32'h0000_0005, 32'h0000_0006, 3'b100, 5'd7,  32'h0000_0000};
        vecs[5] = '{32'h1234_5678, 32'h0000_0010, 3'b000, 5'd8,  32'h2345_6780};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0002, 3'b001, 5'd9,  32'hFFFF_FFFF};
        vecs[7] = '{32'h8000_0000, 32'h0000_0002, 3'b011, 5'd10, 32'h0000_0001};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 3'b010, 5'd11, 32'hC000_0000};
        vecs[9] = '{32'h0000_0003, 32'h0000_0003, 3'b111, 5'd12, 32'h0000_0000};

        // Reset state
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle();
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Basic MUL latency
        drive(32'd7, 32'hFFFF_FFFD, 3'b000, 5'd3);
        @(negedge clk);
        check("basic_in_ready", in_ready, 1);
        next_cycle();
        idle();
        @(negedge clk);
        check("basic_early_valid", out_valid, 0);
        check("basic_occ1", occupancy, 1);
        next_cycle();
        @(negedge clk);
        check("basic_out_valid", out_valid, 1);
        check("basic_result", out_result, 32'hFFFF_FFEB);
        check("basic_tag", out_tag, 3);
        next_cycle();
        @(negedge clk);
        check("basic_drained", busy, 0);
        next_cycle();

        // Back-to-back table stream: one result per cycle, occupancy steady at 2
        for (int i = 0; i < NVEC + 3; i++) begin
            if (i < NVEC) drive(vecs[i].a, vecs[i].b, vecs[i].f3, vecs[i].tag);
            else idle();
            @(negedge clk);
            acc = (i < NVEC) ? i : NVEC;
            ret = i - 2;
            if (ret < 0) ret = 0;
            if (ret > NVEC) ret = NVEC;
            if (i < NVEC) check($sformatf("vec%0d_in_ready", i), in_ready, 1);
            check($sformatf("cyc%0d_occupancy", i), occupancy, acc - ret);
            if (i >= 2 && i - 2 < NVEC) begin
                check($sformatf("vec%0d_valid", i - 2), out_valid, 1);
                check($sformatf("vec%0d_result", i - 2), out_result, vecs[i-2].exp);
                check($sformatf("vec%0d_tag", i - 2), out_tag, vecs[i-2].tag);
            end else begin
                check($sformatf("cyc%0d_no_valid", i), out_valid, 0);
            end
            next_cycle();
        end

        // Backpressure: head blocked for 3 cycles
        next_tag = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            if (next_tag < 4) drive(32'(next_tag), 32'd1, 3'b000, 5'(next_tag));
            else idle();
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                check($sformatf("bp%0d_occupancy", c), occupancy, 2);
                check($sformatf("bp%0d_in_ready", c), in_ready, 0);
                check($sformatf("bp%0d_out_valid", c), out_valid, 1);
                check($sformatf("bp%0d_out_tag", c), out_tag, 0);
            end
            if (in_valid && in_ready) next_tag++;
            if (out_valid && out_ready) begin
                check($sformatf("bp_result_tag%0d", out_tag), out_result, 32'(out_tag));
                recv.push_back(int'(out_tag));
            end
            next_cycle();
        end
        out_ready = 1'b1;
        check("bp_count", recv.size(), 4);
        for (int k = 0; k < recv.size(); k++) check($sformatf("bp_order%0d", k), recv[k], k);
        check("bp_drained", busy, 0);

        // Flush with two ops in flight and a third offered
        drive(32'd1, 32'd1, 3'b000, 5'd20);
        next_cycle();
        drive(32'd1, 32'd1, 3'b000, 5'd21);
        next_cycle();
        drive(32'd1, 32'd1, 3'b000, 5'd22);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        check("flush_out_valid", out_valid, 0);
        next_cycle();
        flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush_occupancy", occupancy, 0);
        check("flush_busy", busy, 0);
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            next_cycle();
        end
        check("flush_no_result", seen, 0);

        // Asynchronous reset with an op at the head
        drive(32'd4, 32'd5, 3'b000, 5'd1);
        next_cycle();
        idle();
        next_cycle();
        #2;
        check("arst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_occupancy", occupancy, 0);
        check("arst_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        drive(32'd2, 32'd3, 3'b000, 5'd2);
        @(negedge clk);
        check("arst_new_in_ready", in_ready, 1);
        next_cycle();
        idle();
        @(negedge clk);
        check("arst_new_early", out_valid, 0);
        next_cycle();
        @(negedge clk);
        check("arst_new_valid", out_valid, 1);
        check("arst_new_result", out_result, 6);
        check("arst_new_tag", out_tag, 2);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_pipeline.md
Name: mul_pipeline

Overview:
- Fully pipelined, parametrised-width RV32M multiplier for the execute stage; successor to the single-op stalling multiplier.
- Accepts one MUL/MULH/MULHSU/MULHU per cycle over a valid/ready handshake and keeps up to DEPTH operations in flight.
- Carries a destination tag with each operation and supports backpressure, flush on mispredict/trap, and occupancy reporting.

Parameters:
- WIDTH, 32, operand and result width in bits (>=2).
- DEPTH, 2, number of pipeline register stages, which equals the accept-to-result latency (>=1).
- TAG_W, 5, width of the sideband tag carried with each operation (e.g. rd index).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept this cycle.
- in_a  in  WIDTH  rs1 operand.
- in_b  in  WIDTH  rs2 operand.
- in_funct3  in  3  mulr/mulhr/mulhsur/mulhur encodings.
- in_tag  in  TAG_W  sideband tag.
- flush  in  1  kill all in-flight operations.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  selected product half.
- out_tag  out  TAG_W  tag of the result.
- occupancy  out  $clog2(DEPTH+1)  count of valid stages.
- busy  out  1  occupancy != 0.

Behaviour:
- Reset (rst_n=0, async): all stage valid bits, occupancy, and stage data registers are 0. out_valid=0, out_result=0, out_tag=0, busy=0.
- Stage data: each stage holds valid, 2*WIDTH product, funct3 and tag.
- Product computation:
  - Computed combinationally from in_a/in_b at acceptance and registered into stage 1.
  - Stage k moves to stage k+1 when the pipeline advances; stage DEPTH drives the outputs.
- advance = ~(v[DEPTH] & ~out_ready). The whole pipe freezes only while the head result is blocked. Bubbles do not compress.
- in_ready = advance & ~flush.
- Accept = in_valid & in_ready. On advance, stage 1 valid <= accept.
- Latency: result appears at out_valid exactly DEPTH cycles after accept when there is no backpressure. Throughput is 1 per cycle.
- out_valid = v[DEPTH] & ~flush. Results emerge in acceptance order.
- Signedness:
  - mulr and mulhr: signed x signed.
  - mulhsur: signed a x unsigned b.
  - mulhur: unsigned x unsigned.
  - Operands are extended to WIDTH+1 bits and the product is truncated to 2*WIDTH.
- Output select:
  - mulr gives product[WIDTH-1:0].
  - mulh* gives product[2*WIDTH-1:WIDTH].
  - funct3[2]=1 (non-multiply) is still accepted, producing out_result=0 with its tag.
- Flush (synchronous):
  - At the next edge all valid bits and occupancy clear. Data registers need not clear.
  - In the flush cycle in_ready=0 and out_valid=0, so neither handshake completes.
  - Flush overrides backpressure.
- Occupancy bookkeeping:
  - occupancy += accept, and -= (out_valid & out_ready).
  - Simultaneous accept and retire leaves it unchanged. It never exceeds DEPTH.
  - When full with the head blocked, in_ready=0.
- Reset asserted mid-operation drops all in-flight operations with no output. After deassertion the first accept gets standard latency.
- occupancy and busy are registered or derived from registered state only. No combinational path from in_valid to in_ready.

Decomposition:
- rv32imc_types (shared package):
  - Existing funct3 constants mulr/mulhr/mulhsur/mulhur.
  - Add an enum mul_sign_t {MUL_SS, MUL_SU, MUL_UU} and a function funct3 -> mul_sign_t.
- Sub-module mul_core_comb #(WIDTH): purely combinational signed/unsigned WIDTH x WIDTH -> 2*WIDTH product.
- Stages are a generate loop in mul_pipeline.

Test Plan (WIDTH=32, DEPTH=2, TAG_W=5):
- Basic MUL: a=7, b=0xFFFFFFFD, funct3=mulr, tag=3, out_ready=1 -> out_valid exactly 2 cycles after accept, out_result=0xFFFFFFEB, out_tag=3.
- High halves, back-to-back over 3 cycles:
  - mulhr 0x80000000 x 0x80000000 -> 0x40000000.
  - mulhur 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - mulhsur 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
  - All three arrive on consecutive cycles.
- Backpressure: issue tags 0..3 every cycle, with out_ready=0 from when tag 0 emerges for 3 cycles -> occupancy=2, in_ready=0, out_tag held at 0; after release, tags 0,1,2,3 emerge in order, none lost or duplicated.
- Flush: 2 ops in flight plus in_valid=1 during the flush cycle -> in_ready=0 and out_valid=0 that cycle; next cycle occupancy=0 and busy=0; no result for those tags ever appears.
- Async reset mid-op: accept an op, drop rst_n between edges -> out_valid and occupancy go to 0 immediately (before the next edge); after release, a new op mulr 2x3 -> 6 after 2 cycles.
- Simultaneous accept/retire with full pipe: steady stream with out_ready=1 -> occupancy constant at 2; funct3=3'b100 op yields out_result=0.
